// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the ALU requesters and alu_arbiter.
// Operands and opcodes are packed per requester: requester i owns [i*W +: W]
// of srca/srcb and [i*3 +: 3] of alucontrol.
interface alu_arbiter_if #(
  parameter int NREQ = 2,
  parameter int W    = 32
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_srca;
  logic [NREQ*W-1:0] req_srcb;
  logic [NREQ*3-1:0] req_alucontrol;
  logic [NREQ-1:0]   resp_valid;
  logic [NREQ-1:0]   resp_ready;
  logic [W-1:0]      resp_aluout;
  logic              resp_zero;

  // Requester side
  modport master (
    output req_valid, req_srca, req_srcb, req_alucontrol, resp_ready,
    input  req_ready, resp_valid, resp_aluout, resp_zero
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_srca, req_srcb, req_alucontrol, resp_ready,
    output req_ready, resp_valid, resp_aluout, resp_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU among NREQ
// requesters. A request is accepted in IDLE, its operands are registered and
// driven to the ALU for one EXEC cycle, and the registered result is offered
// to the winner in RESP until that requester accepts it.
module alu_arbiter #(
  parameter int NREQ = 2,
  parameter int W    = 32
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus,
  output logic [W-1:0] alu_srca,
  output logic [W-1:0] alu_srcb,
  output logic [2:0]   alu_alucontrol,
  input  logic [W-1:0] alu_aluout,
  input  logic         alu_zero,
  output logic         busy,
  output logic [1:0]   grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;

  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [2:0]   op_ctl;
  logic [W-1:0] res;
  logic         res_zero;
  logic [1:0]   owner;
  logic [1:0]   rr_ptr;

  logic         found;
  logic [1:0]   winner;
  logic [W-1:0] sel_a;
  logic [W-1:0] sel_b;
  logic [2:0]   sel_ctl;
  logic         resp_ack;

  // Pick the first valid requester starting at rr_ptr and select its operands
  always_comb begin
    int idx;
    found   = 1'b0;
    winner  = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_ctl = '0;
    idx     = 0;
    // Walk offsets from farthest to nearest so the nearest valid one wins last
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      for (int j = 0; j < NREQ; j++) begin
        if ((j == idx) && bus.req_valid[j]) begin
          found  = 1'b1;
          winner = 2'(j);
        end
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (winner == 2'(j)) begin
        sel_a   = bus.req_srca[j*W +: W];
        sel_b   = bus.req_srcb[j*W +: W];
        sel_ctl = bus.req_alucontrol[j*3 +: 3];
      end
    end
  end

  // Decode per-requester handshakes; only the owner's resp_ready matters
  always_comb begin
    bus.req_ready  = '0;
    bus.resp_valid = '0;
    resp_ack       = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      bus.req_ready[j]  = (state == IDLE) && found && (winner == 2'(j));
      bus.resp_valid[j] = (state == RESP) && (owner == 2'(j));
      if ((owner == 2'(j)) && bus.resp_ready[j]) begin
        resp_ack = 1'b1;
      end
    end
  end

  // Next-state logic: accept, one execute cycle, then wait for the owner
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (found) state_nxt = EXEC;
      EXEC: state_nxt = RESP;
      RESP: if (resp_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset aborts any transaction in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand capture on accept, result capture in EXEC, pointer advance on completion
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a     <= '0;
      op_b     <= '0;
      op_ctl   <= 3'b000;
      res      <= '0;
      res_zero <= 1'b0;
      owner    <= '0;
      rr_ptr   <= '0;
    end else begin
      if ((state == IDLE) && found) begin
        op_a   <= sel_a;
        op_b   <= sel_b;
        op_ctl <= sel_ctl;
        owner  <= winner;
      end
      if (state == EXEC) begin
        res      <= alu_aluout;
        res_zero <= alu_zero;
      end
      if ((state == RESP) && resp_ack) begin
        rr_ptr <= (owner == 2'(NREQ - 1)) ? 2'd0 : owner + 2'd1;
      end
    end
  end

  assign alu_srca        = op_a;
  assign alu_srcb        = op_b;
  assign alu_alucontrol  = op_ctl;
  assign bus.resp_aluout = res;
  assign bus.resp_zero   = res_zero;
  assign busy            = (state != IDLE);
  assign grant_id        = owner;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a behavioural MIPS ALU attached to
// the alu_* ports. Inputs change on the falling edge; outputs are sampled 1ns
// after the falling edge, well away from the rising edge.
module tb_alu_arbiter;

  localparam int NREQ = 2;
  localparam int W    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  alu_srca;
  logic [W-1:0]  alu_srcb;
  logic [2:0]    alu_alucontrol;
  logic [W-1:0]  alu_aluout;
  logic          alu_zero;
  logic          busy;
  logic [1:0]    grant_id;

  int compare_count  = 0;
  int mismatch_count = 0;

  alu_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  alu_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .alu_srca       (alu_srca),
    .alu_srcb       (alu_srcb),
    .alu_alucontrol (alu_alucontrol),
    .alu_aluout     (alu_aluout),
    .alu_zero       (alu_zero),
    .busy           (busy),
    .grant_id       (grant_id)
  );

  always #5 clk = ~clk;

  // Behavioural ALU standing in for the shared datapath ALU
  always_comb begin
    case (alu_alucontrol)
      3'b010:  alu_aluout = alu_srca + alu_srcb;
      3'b110:  alu_aluout = alu_srca - alu_srcb;
      3'b000:  alu_aluout = alu_srca & alu_srcb;
      3'b001:  alu_aluout = alu_srca | alu_srcb;
      3'b111:  alu_aluout = ($signed(alu_srca) < $signed(alu_srcb)) ? 32'd1 : 32'd0;
      default: alu_aluout = 32'd0;
    endcase
  end
  assign alu_zero = (alu_aluout == 32'd0);

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compare_count++;
    if (actual !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [31:0] a, input logic [31:0] b, input logic [2:0] ctl);
    bus.req_valid[idx]               = 1'b1;
    bus.req_srca[idx*W +: W]         = a;
    bus.req_srcb[idx*W +: W]         = b;
    bus.req_alucontrol[idx*3 +: 3]   = ctl;
  endtask

  logic [1:0] exp_grant [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    int n;
    int last_cyc;
    reset              = 1'b1;
    bus.req_valid      = '0;
    bus.req_srca       = '0;
    bus.req_srcb       = '0;
    bus.req_alucontrol = '0;
    bus.resp_ready     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'h0);
    checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_grant_id", 32'(grant_id), 32'h0);
    checkOutput("rst_aluout", bus.resp_aluout, 32'h0);
    checkOutput("rst_zero", 32'(bus.resp_zero), 32'h0);
    checkOutput("rst_alu_srca", alu_srca, 32'h0);
    reset = 1'b0;

    // Single add from requester 0
    @(negedge clk);
    applyStimulus(0, 32'h0000_0005, 32'h0000_0003, 3'b010);
    #1;
    checkOutput("add_ready", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    checkOutput("add_exec_busy", 32'(busy), 32'h1);
    checkOutput("add_exec_rvalid", 32'(bus.resp_valid), 32'h0);
    checkOutput("add_exec_ready", 32'(bus.req_ready), 32'h0);
    checkOutput("add_exec_srca", alu_srca, 32'h5);
    checkOutput("add_exec_ctl", 32'(alu_alucontrol), 32'h2);
    @(negedge clk);
    #1;
    checkOutput("add_resp_valid", 32'(bus.resp_valid), 32'h1);
    checkOutput("add_resp_aluout", bus.resp_aluout, 32'h0000_0008);
    checkOutput("add_resp_zero", 32'(bus.resp_zero), 32'h0);
    checkOutput("add_grant_id", 32'(grant_id), 32'h0);
    bus.resp_ready = 2'b01;
    @(negedge clk);
    bus.resp_ready = 2'b00;
    #1;
    checkOutput("add_done_busy", 32'(busy), 32'h0);
    checkOutput("add_done_rvalid", 32'(bus.resp_valid), 32'h0);

    // Subtract to zero from requester 1, response held under backpressure
    @(negedge clk);
    applyStimulus(1, 32'h1234_5678, 32'h1234_5678, 3'b110);
    #1;
    checkOutput("sub_ready", 32'(bus.req_ready), 32'h2);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    #1;
    checkOutput("sub_resp_valid", 32'(bus.resp_valid), 32'h2);
    checkOutput("sub_resp_aluout", bus.resp_aluout, 32'h0);
    checkOutput("sub_resp_zero", 32'(bus.resp_zero), 32'h1);
    checkOutput("sub_grant_id", 32'(grant_id), 32'h1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      checkOutput("sub_hold_valid", 32'(bus.resp_valid), 32'h2);
      checkOutput("sub_hold_aluout", bus.resp_aluout, 32'h0);
      checkOutput("sub_hold_zero", 32'(bus.resp_zero), 32'h1);
    end
    bus.resp_ready = 2'b10;
    @(negedge clk);
    bus.resp_ready = 2'b00;
    #1;
    checkOutput("sub_done_busy", 32'(busy), 32'h0);

    // Signed slt from requester 0, then non-owner resp_ready is ignored
    @(negedge clk);
    applyStimulus(0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b111);
    #1;
    checkOutput("slt_ready", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    #1;
    checkOutput("slt_resp_valid", 32'(bus.resp_valid), 32'h1);
    checkOutput("slt_resp_aluout", bus.resp_aluout, 32'h0000_0001);
    checkOutput("slt_resp_zero", 32'(bus.resp_zero), 32'h0);
    bus.resp_ready = 2'b10;
    applyStimulus(1, 32'hAAAA_0000, 32'h0000_5555, 3'b001);
    #1;
    checkOutput("bp_req_ready", 32'(bus.req_ready), 32'h0);
    @(negedge clk);
    #1;
    checkOutput("bp_resp_valid", 32'(bus.resp_valid), 32'h1);
    checkOutput("bp_busy", 32'(busy), 32'h1);
    checkOutput("bp_req_ready2", 32'(bus.req_ready), 32'h0);
    bus.resp_ready = 2'b01;
    bus.req_valid  = '0;
    @(negedge clk);
    bus.resp_ready = 2'b00;
    #1;
    checkOutput("bp_done_busy", 32'(busy), 32'h0);

    // Reset while the result waits in RESP
    @(negedge clk);
    applyStimulus(0, 32'h0000_0007, 32'h0000_0005, 3'b110);
    #1;
    checkOutput("abort_ready", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    #1;
    checkOutput("abort_resp_valid", 32'(bus.resp_valid), 32'h1);
    checkOutput("abort_resp_aluout", bus.resp_aluout, 32'h0000_0002);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("abort_rvalid", 32'(bus.resp_valid), 32'h0);
    checkOutput("abort_busy", 32'(busy), 32'h0);
    checkOutput("abort_grant_id", 32'(grant_id), 32'h0);
    checkOutput("abort_aluout", bus.resp_aluout, 32'h0);

    // Both valid right after reset: pointer is back at 0, so requester 0 wins
    applyStimulus(0, 32'h0000_0001, 32'h0000_0001, 3'b010);
    applyStimulus(1, 32'h0F0F_0000, 32'h0000_F0F0, 3'b001);
    #1;
    checkOutput("rst_rrptr_ready", 32'(bus.req_ready), 32'h1);
    bus.req_valid[0] = 1'b0;
    #1;
    checkOutput("skip_dropped_ready", 32'(bus.req_ready), 32'h2);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    #1;
    checkOutput("req1_resp_valid", 32'(bus.resp_valid), 32'h2);
    checkOutput("req1_resp_aluout", bus.resp_aluout, 32'h0F0F_F0F0);
    checkOutput("req1_grant_id", 32'(grant_id), 32'h1);
    bus.resp_ready = 2'b10;
    @(negedge clk);
    bus.resp_ready = 2'b00;

    // Round robin with both requesters continuously valid
    applyStimulus(0, 32'd100, 32'd23, 3'b010);
    applyStimulus(1, 32'hFF00_FF00, 32'h0FF0_0FF0, 3'b000);
    bus.resp_ready = 2'b11;
    n        = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      #1;
      if (bus.req_ready != 2'b00) begin
        if (n < 4) checkOutput("rr_grant", 32'(bus.req_ready), 32'(exp_grant[n]));
        if (n > 0) checkOutput("rr_gap", 32'(cyc - last_cyc), 32'd3);
        last_cyc = cyc;
        n++;
      end
      if (bus.resp_valid == 2'b01) begin
        checkOutput("rr_result0", bus.resp_aluout, 32'h0000_007B);
      end else if (bus.resp_valid == 2'b10) begin
        checkOutput("rr_result1", bus.resp_aluout, 32'h0F00_0F00);
      end
      @(negedge clk);
    end
    bus.req_valid  = '0;
    bus.resp_ready = 2'b00;
    checkOutput("rr_count", 32'(n), 32'd4);
    @(negedge clk);
    #1;
    checkOutput("rr_idle_busy", 32'(busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
